// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU package for the instruction fetch unit.
// Holds the fetch FSM state encoding, the NOP word used for squashed or idle
// slots, the PC increment constant and a saturating-increment helper.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pc_next_select.sv
// Next-PC selection for the instruction fetch unit.
// Priority: jump > branch > stall (hold) > sequential PC+4. A redirect wins
// over a stall. Redirect targets are forced word-aligned and a nonzero low
// pair of bits is reported through misaligned.
// Ports:
//   pc            current PC
//   pc_write      1 = advance, 0 = hold
//   branch_taken / branch_target   conditional redirect
//   jump_taken   / jump_target     unconditional redirect
//   pc_plus4      pc + 4, wrapping modulo 2^32
//   next_pc       selected next PC
//   redirect      a branch or jump is being taken
//   misaligned    the taken redirect target had bits [1:0] nonzero
module pc_next_select
  import instruction_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        misaligned
);

  logic [31:0] target;

  // NOTE: every signal written in a combinational block gets a default at the
  // top so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    pc_plus4   = pc + PC_INC;
    redirect   = jump_taken | branch_taken;
    target     = jump_taken ? jump_target : branch_target;
    misaligned = redirect && (target[1:0] != 2'b00);
    next_pc    = pc;
    if (redirect) begin
      next_pc = {target[31:2], 2'b00};
    end else if (pc_write) begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, BOOT/RUN/HALT fetch FSM, sticky
// alignment error flag and saturating issued-instruction counter.
// Ports:
//   Clk, Reset (async active-low)
//   PCWrite                       1 = advance, 0 = stall
//   BranchTaken/BranchTarget      conditional redirect request
//   JumpTaken/JumpTarget          unconditional redirect request
//   ImemRdata                     instruction word for ImemAddr (combinational)
//   ImemAddr                      current PC
//   Instruction, PCAddResult      word and PC+4 for the fetch/decode register
//   Write, Flush                  load enable / squash for that register
//   Halted, AlignErr, FetchCount  status
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] ImemRdata,
  output logic [31:0] ImemAddr,
  output logic [31:0] Instruction,
  output logic [31:0] PCAddResult,
  output logic        Write,
  output logic        Flush,
  output logic        Halted,
  output logic        AlignErr,
  output logic [31:0] FetchCount
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next, sel_next_pc, pc_plus4;
  logic         redirect, misaligned;
  logic         align_err, align_set;
  logic [31:0]  fetch_count;
  logic         count_en;

  pc_next_select u_pc_next_select (
    .pc            (pc),
    .pc_write      (PCWrite),
    .branch_taken  (BranchTaken),
    .branch_target (BranchTarget),
    .jump_taken    (JumpTaken),
    .jump_target   (JumpTarget),
    .pc_plus4      (pc_plus4),
    .next_pc       (sel_next_pc),
    .redirect      (redirect),
    .misaligned    (misaligned)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      align_err   <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (align_set) align_err <= 1'b1;
      if (count_en)  fetch_count <= sat_inc(fetch_count);
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    Instruction = NOP_WORD;
    Write       = 1'b0;
    Flush       = 1'b0;
    count_en    = 1'b0;
    align_set   = 1'b0;
    case (state)
      // One squashed slot while the PC sits at RESET_PC.
      ST_BOOT: begin
        Write      = 1'b1;
        Flush      = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        pc_next = sel_next_pc;
        if (redirect) begin
          // Whatever memory returned this cycle is on the wrong path.
          Write     = 1'b1;
          Flush     = 1'b1;
          align_set = misaligned;
        end else if (PCWrite) begin
          Instruction = ImemRdata;
          Write       = 1'b1;
          count_en    = 1'b1;
          // The halt word itself is still handed to decode.
          if (ImemRdata == HALT_WORD) state_next = ST_HALT;
        end else begin
          Instruction = ImemRdata;
        end
      end
      ST_HALT: begin
        // Only Reset leaves HALT; requests are ignored.
      end
      default: state_next = ST_BOOT;
    endcase
  end

  assign ImemAddr    = pc;
  assign PCAddResult = pc_plus4;
  assign Halted      = (state == ST_HALT);
  assign AlignErr    = align_err;
  assign FetchCount  = fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit. Issued instructions
// (Write=1, Flush=0) are checked by a negedge monitor against a queue of
// expected {Instruction, ImemAddr, PCAddResult}; control/status outputs are
// checked directly by the stimulus process.
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] pc_add;
  } issue_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PCWrite;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        JumpTaken;
  logic [31:0] JumpTarget;
  logic [31:0] ImemRdata;
  logic [31:0] ImemAddr;
  logic [31:0] Instruction;
  logic [31:0] PCAddResult;
  logic        Write;
  logic        Flush;
  logic        Halted;
  logic        AlignErr;
  logic [31:0] FetchCount;

  int tests = 0;
  int fails = 0;
  issue_t exp_q[$];

  instruction_fetch_unit dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCWrite      (PCWrite),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .JumpTaken    (JumpTaken),
    .JumpTarget   (JumpTarget),
    .ImemRdata    (ImemRdata),
    .ImemAddr     (ImemAddr),
    .Instruction  (Instruction),
    .PCAddResult  (PCAddResult),
    .Write        (Write),
    .Flush        (Flush),
    .Halted       (Halted),
    .AlignErr     (AlignErr),
    .FetchCount   (FetchCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_issue(input logic [31:0] instr, input logic [31:0] addr,
                              input logic [31:0] pc_add);
    issue_t e;
    e.instr  = instr;
    e.addr   = addr;
    e.pc_add = pc_add;
    exp_q.push_back(e);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    PCWrite      = 1'b1;
    BranchTaken  = 1'b0;
    BranchTarget = '0;
    JumpTaken    = 1'b0;
    JumpTarget   = '0;
  endtask

  // Monitor: every issued instruction must match the oldest expectation.
  always @(negedge Clk) begin
    if (Reset === 1'b1 && Write === 1'b1 && Flush === 1'b0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: got %08h @ %08h, none expected", Instruction, ImemAddr);
      end else begin
        issue_t e;
        e = exp_q.pop_front();
        check("issue_instr", Instruction, e.instr);
        check("issue_addr", ImemAddr, e.addr);
        check("issue_pcadd", PCAddResult, e.pc_add);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b0;
    ImemRdata = 32'h2002_0005;
    idle_inputs();

    // Reset state.
    #3;
    check("rst_addr", ImemAddr, 32'h0);
    check("rst_halted", {31'b0, Halted}, 32'd0);
    check("rst_alignerr", {31'b0, AlignErr}, 32'd0);
    check("rst_count", FetchCount, 32'd0);

    // Release away from the edge; BOOT cycle.
    cyc();
    Reset = 1'b1;
    settle();
    check("boot_flush", {31'b0, Flush}, 32'd1);
    check("boot_write", {31'b0, Write}, 32'd1);
    check("boot_instr", Instruction, 32'h0);

    // First RUN fetch at 0.
    cyc();
    check("run0_count", FetchCount, 32'd0);
    expect_issue(32'h2002_0005, 32'h0, 32'h4);

    // PC=4: jump to 0x10.
    cyc();
    check("run1_count", FetchCount, 32'd1);
    JumpTaken  = 1'b1;
    JumpTarget = 32'h10;
    settle();
    check("jmp_flush", {31'b0, Flush}, 32'd1);

    // Stall three cycles at 0x10.
    cyc();
    idle_inputs();
    PCWrite   = 1'b0;
    ImemRdata = 32'h00A0_0093;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_addr", ImemAddr, 32'h10);
      check("stall_write", {31'b0, Write}, 32'd0);
      check("stall_flush", {31'b0, Flush}, 32'd0);
      check("stall_count", FetchCount, 32'd1);
      cyc();
    end
    PCWrite = 1'b1;
    expect_issue(32'h00A0_0093, 32'h10, 32'h14);

    cyc();
    check("unstall_addr", ImemAddr, 32'h14);
    check("unstall_count", FetchCount, 32'd2);
    ImemRdata = 32'h0000_0013;
    expect_issue(32'h0000_0013, 32'h14, 32'h18);
    cyc();
    expect_issue(32'h0000_0013, 32'h18, 32'h1C);
    cyc();
    expect_issue(32'h0000_0013, 32'h1C, 32'h20);

    // PC=0x20: stall + branch + jump together, with the halt word on the bus.
    cyc();
    check("pri_addr", ImemAddr, 32'h20);
    check("pri_count", FetchCount, 32'd5);
    PCWrite      = 1'b0;
    BranchTaken  = 1'b1;
    BranchTarget = 32'h40;
    JumpTaken    = 1'b1;
    JumpTarget   = 32'h80;
    ImemRdata    = 32'hFFFF_FFFF;
    settle();
    check("pri_flush", {31'b0, Flush}, 32'd1);
    check("pri_instr", Instruction, 32'h0);
    check("pri_write", {31'b0, Write}, 32'd1);

    cyc();
    idle_inputs();
    ImemRdata = 32'h0000_0013;
    check("pri_next_addr", ImemAddr, 32'h80);
    check("pri_no_halt", {31'b0, Halted}, 32'd0);
    check("pri_no_count", FetchCount, 32'd5);
    check("pri_alignerr", {31'b0, AlignErr}, 32'd0);
    expect_issue(32'h0000_0013, 32'h80, 32'h84);

    // Misaligned branch.
    cyc();
    BranchTaken  = 1'b1;
    BranchTarget = 32'h103;
    cyc();
    idle_inputs();
    check("mis_addr", ImemAddr, 32'h100);
    check("mis_alignerr", {31'b0, AlignErr}, 32'd1);
    expect_issue(32'h0000_0013, 32'h100, 32'h104);

    // Jump to the top of the address space.
    cyc();
    check("sticky_alignerr", {31'b0, AlignErr}, 32'd1);
    JumpTaken  = 1'b1;
    JumpTarget = 32'hFFFF_FFFC;
    cyc();
    idle_inputs();
    ImemRdata = 32'h1234_5678;
    check("wrap_addr", ImemAddr, 32'hFFFF_FFFC);
    check("wrap_pcadd", PCAddResult, 32'h0);
    expect_issue(32'h1234_5678, 32'hFFFF_FFFC, 32'h0);

    cyc();
    check("wrapped_addr", ImemAddr, 32'h0);
    check("wrapped_count", FetchCount, 32'd8);
    // Preset the counter to its ceiling before this cycle's issue.
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count;
    expect_issue(32'h1234_5678, 32'h0, 32'h4);

    // Halt word issued at PC=4.
    cyc();
    check("sat_count", FetchCount, 32'hFFFF_FFFF);
    ImemRdata = 32'hFFFF_FFFF;
    expect_issue(32'hFFFF_FFFF, 32'h4, 32'h8);
    settle();
    check("halt_issue_write", {31'b0, Write}, 32'd1);

    cyc();
    BranchTaken  = 1'b1;
    BranchTarget = 32'h200;
    settle();
    check("halted", {31'b0, Halted}, 32'd1);
    check("halt_write", {31'b0, Write}, 32'd0);
    check("halt_flush", {31'b0, Flush}, 32'd0);
    check("halt_instr", Instruction, 32'h0);
    check("halt_count", FetchCount, 32'hFFFF_FFFF);
    cyc();
    check("halt_hold_addr", ImemAddr, 32'h8);
    check("halt_stays", {31'b0, Halted}, 32'd1);

    // Asynchronous reset with a redirect pending.
    Reset = 1'b0;
    settle();
    check("areset_halted", {31'b0, Halted}, 32'd0);
    check("areset_addr", ImemAddr, 32'h0);
    check("areset_alignerr", {31'b0, AlignErr}, 32'd0);
    check("areset_count", FetchCount, 32'd0);
    cyc();
    Reset = 1'b1;
    idle_inputs();
    ImemRdata = 32'h2002_0005;
    settle();
    check("reboot_flush", {31'b0, Flush}, 32'd1);
    cyc();
    check("reboot_addr", ImemAddr, 32'h0);
    expect_issue(32'h2002_0005, 32'h0, 32'h4);
    cyc();
    check("reboot_count", FetchCount, 32'd1);
    PCWrite = 1'b0;
    cyc();
    cyc();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that stops fetch.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 PCWrite  input  1  1 = advance PC; 0 = stall (hold PC, hold decode register).
REQ-006 BranchTaken  input  1  conditional-branch redirect request from a later stage.
REQ-007 BranchTarget  input  32  branch destination byte address.
REQ-008 JumpTaken  input  1  unconditional-jump redirect request.
REQ-009 JumpTarget  input  32  jump destination byte address.
REQ-010 ImemRdata  input  32  instruction word returned combinationally for ImemAddr.
REQ-011 ImemAddr  output  32  current PC driven to instruction memory.
REQ-012 Instruction  output  32  instruction to the fetch/decode pipeline register.
REQ-013 PCAddResult  output  32  PC+4 of the instruction on Instruction.
REQ-014 Write  output  1  load enable for the fetch/decode pipeline register.
REQ-015 Flush  output  1  1 = instruction on Instruction is squashed.
REQ-016 Halted  output  1  1 while the FSM is in HALT.
REQ-017 AlignErr  output  1  sticky flag: a redirect target had bits [1:0] nonzero.
REQ-018 FetchCount  output  32  number of instructions issued in RUN.

Function
REQ-019 FSM states SHALL be BOOT, RUN, HALT; BOOT->RUN after exactly one cycle; RUN->HALT when a non-flushed issued word equals HALT_WORD; HALT is left only by Reset.
REQ-020 In BOOT: PC = RESET_PC, Instruction = 0, Write = 1, Flush = 1, FetchCount unchanged.
REQ-021 In RUN: Instruction = ImemRdata, PCAddResult = PC+4, ImemAddr = PC, combinationally from the PC register.
REQ-022 Next-PC priority SHALL be JumpTaken > BranchTaken > PCWrite==0 (hold) > PC+4.
REQ-023 Redirect SHALL override stall: a redirect with PCWrite=0 still loads the target.
REQ-024 Redirect cycle: Flush = 1, Instruction = 0, Write = 1; next-cycle PC = target with bits [1:0] cleared.
REQ-025 Nonzero target bits [1:0] on any accepted redirect SHALL set AlignErr, cleared only by Reset.
REQ-026 Stall (PCWrite=0, no redirect): PC holds, Write = 0, Flush = 0, FetchCount holds.
REQ-027 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no error.
REQ-028 FetchCount SHALL increment by 1 on each RUN cycle with Write=1 and Flush=0, saturating at 32'hFFFF_FFFF.
REQ-029 Cycle that detects HALT_WORD: word is issued normally (Write=1), FSM enters HALT next cycle.
REQ-030 HALT_WORD seen in a redirect cycle SHALL NOT halt (word is squashed).
REQ-031 In HALT: PC holds, Instruction = 0, Write = 0, Flush = 0, Halted = 1; redirect/stall inputs ignored.

Reset
REQ-032 Reset=0 SHALL asynchronously set state BOOT, PC = RESET_PC, AlignErr = 0, FetchCount = 0, Halted = 0.
REQ-033 Reset asserted mid-redirect or mid-stall SHALL discard the pending request; first post-reset fetch is RESET_PC.
REQ-034 Reset release SHALL be treated synchronously to Clk; BOOT lasts one full cycle after release.

Structure
REQ-035 FSM state encoding, NOP word (32'h0) and PC increment constant (4) SHALL live in the shared CPU package.
REQ-036 Next-PC selection SHALL be one sub-module, pc_next_select (combinational priority mux + alignment check); PC register, FSM and counter stay in the top.

Verification
REQ-037 Reset release, ImemRdata=32'h2002_0005, no requests -> cycle 0 Flush=1/Instruction=0; cycle 1 ImemAddr=0, PCAddResult=4, FetchCount 0->1.
REQ-038 PC=0x10, PCWrite=0 for 3 cycles -> ImemAddr stays 0x10, Write=0, FetchCount unchanged; release -> ImemAddr 0x14.
REQ-039 PC=0x20, PCWrite=0, BranchTaken=1, JumpTaken=1, BranchTarget=0x40, JumpTarget=0x80 -> Flush=1, Instruction=0, next ImemAddr=0x80.
REQ-040 BranchTaken=1, BranchTarget=0x103 -> next ImemAddr=0x100, AlignErr=1 and stays 1 until Reset.
REQ-041 ImemRdata=32'hFFFF_FFFF in RUN -> issued with Write=1, next cycle Halted=1, Write=0; BranchTaken=1 ignored; Reset=0 -> BOOT, PC=RESET_PC.
REQ-042 PC=32'hFFFF_FFFC, no requests -> next ImemAddr=0, PCAddResult was 0; FetchCount preset 32'hFFFF_FFFF stays saturated.
